day_input_rom_server: RTL and testbench

- Responder end of the puzzle-input ROM interface that every dayNN core reads through (`rom_addr` out of the core; `rom_data`/`rom_valid` back into it).
- Holds a byte-wide input image: loaded once through a valid/ready byte stream from the host loader, then served read-only to the core.
- Served reads have a fixed, parameterised latency.
- Addresses past the loaded length return a 0x00 end-of-input sentinel, so cores detect EOF without knowing the length.

---
 rtl/day_input_rom_server_if.sv | 23 ++
 rtl/day_input_rom_server.sv | 134 +++++++++++++
 tb/tb_day_input_rom_server.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/day_input_rom_server_if.sv
// Byte-stream load port and read-only ROM bus shared between a dayNN core,
// the host loader, and the input ROM server.
interface day_input_rom_server_if #(
    parameter int N_ADDR_BITS = 16
);
    logic [7:0]           load_data;
    logic                 load_valid;
    logic                 load_last;
    logic                 load_ready;
    logic [N_ADDR_BITS:0] rom_addr;
    logic [7:0]           rom_data;
    logic                 rom_valid;

    modport master (
        output load_data, load_valid, load_last, rom_addr,
        input  load_ready, rom_data, rom_valid
    );

    modport slave (
        input  load_data, load_valid, load_last, rom_addr,
        output load_ready, rom_data, rom_valid
    );
endinterface

// File: rtl/day_input_rom_server.sv
// Puzzle-input ROM server: captures a byte image from the host stream once,
// then answers core reads with a fixed latency and a 0x00 end-of-input
// sentinel for any address at or beyond the stored length.
module day_input_rom_server #(
    parameter int N_ADDR_BITS  = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    day_input_rom_server_if.slave  bus,
    output logic                   loaded,
    output logic                   overflow,
    output logic [N_ADDR_BITS:0]   byte_count
);

    localparam int DEPTH = 1 << N_ADDR_BITS;
    localparam logic [N_ADDR_BITS:0] COUNT_ONE = 1;

    typedef enum logic {S_LOAD, S_SERVE} state_t;

    state_t state;
    state_t state_next;

    logic [7:0]           mem [DEPTH];
    logic                 ready_q;
    logic                 xfer;
    logic                 full;
    logic                 wr_en;
    logic                 in_range;
    logic [7:0]           raw_byte;

    logic                 vld_p  [READ_LATENCY];
    logic [N_ADDR_BITS:0] tag_p  [READ_LATENCY];
    logic [7:0]           data_p [READ_LATENCY];

    // Out-of-range reads collapse to the end-of-input marker.
    function automatic logic [7:0] sentinel(input logic hit, input logic [7:0] raw);
        return hit ? raw : 8'h00;
    endfunction

    // byte_count saturates at DEPTH, so its top bit alone flags a full memory.
    assign full     = byte_count[N_ADDR_BITS];
    assign xfer     = (state == S_LOAD) && bus.load_valid && ready_q;
    assign wr_en    = xfer && !full;
    assign in_range = bus.rom_addr < byte_count;
    assign raw_byte = mem[bus.rom_addr[N_ADDR_BITS-1:0]];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next state: the last beat moves to serving whether it was stored or dropped.
    always_comb begin
        state_next = state;
        case (state)
            S_LOAD: begin
                if (xfer && bus.load_last) begin
                    state_next = S_SERVE;
                end
            end
            S_SERVE: begin
                state_next = S_SERVE;
            end
            default: begin
                state_next = S_LOAD;
            end
        endcase
    end

    // Registered handshake and status flags, cleared during reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q <= 1'b0;
            loaded  <= 1'b0;
        end else begin
            ready_q <= (state_next == S_LOAD);
            loaded  <= (state_next == S_SERVE);
        end
    end

    // Write pointer and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) begin
                byte_count <= byte_count + COUNT_ONE;
            end
            if (xfer && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Image storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[byte_count[N_ADDR_BITS-1:0]] <= bus.load_data;
        end
    end

    // Read pipeline: tag, valid and fetched byte travel together; idle while loading.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld_p[i]  <= 1'b0;
                tag_p[i]  <= '0;
                data_p[i] <= 8'h00;
            end
        end else begin
            vld_p[0]  <= (state == S_SERVE);
            tag_p[0]  <= bus.rom_addr;
            data_p[0] <= (state == S_SERVE) ? sentinel(in_range, raw_byte) : 8'h00;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_p[i]  <= vld_p[i-1];
                tag_p[i]  <= tag_p[i-1];
                data_p[i] <= data_p[i-1];
            end
        end
    end

    // Live compare against rom_addr so a moved address drops valid in the same cycle.
    assign bus.rom_valid  = (state == S_SERVE) && vld_p[READ_LATENCY-1] &&
                            (tag_p[READ_LATENCY-1] == bus.rom_addr);
    assign bus.rom_data   = data_p[READ_LATENCY-1];
    assign bus.load_ready = ready_q;

endmodule

// File: tb/tb_day_input_rom_server.sv
// Directed bench for day_input_rom_server: four instances cover the default
// configuration, a small overflowing memory, and read latencies 1 and 4.
module tb_day_input_rom_server;

    logic        clk;
    logic [3:0]  rstv;
    logic [7:0]  ld;
    logic [3:0]  lv;
    logic        llast;
    logic [16:0] addr;

    int tests = 0;
    int fails = 0;

    localparam int LAT [4] = '{2, 2, 1, 4};

    day_input_rom_server_if #(.N_ADDR_BITS(16)) if0 ();
    day_input_rom_server_if #(.N_ADDR_BITS(4))  if1 ();
    day_input_rom_server_if #(.N_ADDR_BITS(8))  if2 ();
    day_input_rom_server_if #(.N_ADDR_BITS(8))  if3 ();

    logic        loaded0, loaded1, loaded2, loaded3;
    logic        ovf0, ovf1, ovf2, ovf3;
    logic [16:0] cnt0;
    logic [4:0]  cnt1;
    logic [8:0]  cnt2, cnt3;

    day_input_rom_server #(.N_ADDR_BITS(16), .READ_LATENCY(2)) u0 (
        .clk(clk), .rst(rstv[0]), .bus(if0), .loaded(loaded0), .overflow(ovf0), .byte_count(cnt0));
    day_input_rom_server #(.N_ADDR_BITS(4), .READ_LATENCY(2)) u1 (
        .clk(clk), .rst(rstv[1]), .bus(if1), .loaded(loaded1), .overflow(ovf1), .byte_count(cnt1));
    day_input_rom_server #(.N_ADDR_BITS(8), .READ_LATENCY(1)) u2 (
        .clk(clk), .rst(rstv[2]), .bus(if2), .loaded(loaded2), .overflow(ovf2), .byte_count(cnt2));
    day_input_rom_server #(.N_ADDR_BITS(8), .READ_LATENCY(4)) u3 (
        .clk(clk), .rst(rstv[3]), .bus(if3), .loaded(loaded3), .overflow(ovf3), .byte_count(cnt3));

    assign if0.load_data = ld;  assign if0.load_valid = lv[0];
    assign if1.load_data = ld;  assign if1.load_valid = lv[1];
    assign if2.load_data = ld;  assign if2.load_valid = lv[2];
    assign if3.load_data = ld;  assign if3.load_valid = lv[3];
    assign if0.load_last = llast; assign if1.load_last = llast;
    assign if2.load_last = llast; assign if3.load_last = llast;
    assign if0.rom_addr = addr;
    assign if1.rom_addr = addr[4:0];
    assign if2.rom_addr = addr[8:0];
    assign if3.rom_addr = addr[8:0];

    logic       vld [4];
    logic       rdy [4];
    logic [7:0] dat [4];
    assign vld[0] = if0.rom_valid; assign vld[1] = if1.rom_valid;
    assign vld[2] = if2.rom_valid; assign vld[3] = if3.rom_valid;
    assign rdy[0] = if0.load_ready; assign rdy[1] = if1.load_ready;
    assign rdy[2] = if2.load_ready; assign rdy[3] = if3.load_ready;
    assign dat[0] = if0.rom_data; assign dat[1] = if1.rom_data;
    assign dat[2] = if2.rom_data; assign dat[3] = if3.rom_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One load beat to every instance selected by mask.
    task automatic send(input logic [3:0] mask, input logic [7:0] b, input logic last);
        @(negedge clk);
        ld = b; llast = last; lv = mask;
        for (int i = 0; i < 4; i++)
            if (mask[i]) check($sformatf("load_ready%0d", i), {31'd0, rdy[i]}, 32'd1);
        @(posedge clk);
        #1;
        lv = 4'b0; llast = 1'b0;
    endtask

    // Count edges until rom_valid on each selected instance (bounded), then check latency and data.
    task automatic wait_valid(input logic [3:0] mask, input logic [7:0] exp, input string tag);
        int         lat [4];
        logic [7:0] d   [4];
        bit         done;
        for (int i = 0; i < 4; i++) begin
            lat[i] = -1;
            d[i]   = 8'hxx;
        end
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            done = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (mask[i] && lat[i] < 0 && vld[i]) begin
                    lat[i] = c;
                    d[i]   = dat[i];
                end
                if (mask[i] && lat[i] < 0) done = 1'b0;
            end
            if (done) break;
        end
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                check($sformatf("%s_lat%0d", tag, i), lat[i], LAT[i]);
                check($sformatf("%s_data%0d", tag, i), {24'd0, d[i]}, {24'd0, exp});
            end
        end
    endtask

    logic [7:0] img  [5] = '{8'h31, 8'h32, 8'h0A, 8'h33, 8'h0A};
    logic [7:0] rexp [7] = '{8'h31, 8'h32, 8'h0A, 8'h33, 8'h0A, 8'h00, 8'h00};

    initial begin
        rstv = 4'h0; ld = 8'h00; lv = 4'h0; llast = 1'b0; addr = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready",  {31'd0, if0.load_ready}, 32'd0);
        check("rst_valid",  {31'd0, if0.rom_valid},  32'd0);
        check("rst_data",   {24'd0, if0.rom_data},   32'd0);
        check("rst_loaded", {31'd0, loaded0},        32'd0);
        check("rst_ovf",    {31'd0, ovf0},           32'd0);
        check("rst_count",  {15'd0, cnt0},           32'd0);
        rstv = 4'hF;
        @(posedge clk);
        #1;
        check("first_ready0", {31'd0, if0.load_ready}, 32'd1);
        check("first_ready1", {31'd0, if1.load_ready}, 32'd1);

        // Load "12\n3\n" into the default, latency-1 and latency-4 instances
        for (int i = 0; i < 5; i++) send(4'b1101, img[i], i == 4);
        check("a_count",  {15'd0, cnt0}, 32'd5);
        check("a_loaded", {31'd0, loaded0}, 32'd1);
        check("a_ovf",    {31'd0, ovf0}, 32'd0);
        check("a_ready",  {31'd0, if0.load_ready}, 32'd0);
        check("a_count3", {23'd0, cnt3}, 32'd5);
        wait_valid(4'b1101, 8'h31, "addr0");

        // Step addresses 0..6, holding each until valid
        for (int a = 1; a < 7; a++) begin
            @(negedge clk);
            addr = 17'(a);
            #1;
            for (int i = 0; i < 4; i++)
                if (i != 1) check($sformatf("step%0d_drop%0d", a, i), {31'd0, vld[i]}, 32'd0);
            wait_valid(4'b1101, rexp[a], $sformatf("step%0d", a));
        end

        // Overflow: 20 bytes into a 16-byte memory, last on the 20th
        for (int i = 0; i < 20; i++) begin
            send(4'b0010, 8'(8'h40 + i), i == 19);
            if (i == 15) begin
                check("ovf_count16", {27'd0, cnt1}, 32'd16);
                check("ovf_not_yet", {31'd0, ovf1}, 32'd0);
            end
            if (i == 16) begin
                check("ovf_set",  {31'd0, ovf1}, 32'd1);
                check("ovf_sat",  {27'd0, cnt1}, 32'd16);
            end
        end
        check("ovf_loaded", {31'd0, loaded1}, 32'd1);
        check("ovf_final",  {31'd0, ovf1}, 32'd1);
        check("ovf_cnt",    {27'd0, cnt1}, 32'd16);
        check("ovf_ready",  {31'd0, if1.load_ready}, 32'd0);
        @(negedge clk);
        addr = 17'd15;
        wait_valid(4'b0010, 8'h4F, "ovf_a15");
        @(negedge clk);
        addr = 17'd16;
        wait_valid(4'b0010, 8'h00, "ovf_a16");

        // Address change while valid drops valid in the same cycle
        @(negedge clk);
        addr = 17'd1;
        wait_valid(4'b0001, 8'h32, "chg_a1");
        @(posedge clk);
        #1;
        check("chg_hold", {31'd0, if0.rom_valid}, 32'd1);
        @(negedge clk);
        addr = 17'd2;
        #1;
        check("chg_drop", {31'd0, if0.rom_valid}, 32'd0);
        wait_valid(4'b0001, 8'h0A, "chg_a2");

        // Reset while serving, then reset mid-load, then reload two bytes
        @(negedge clk);
        rstv[0] = 1'b0;
        #1;
        check("mr_valid",  {31'd0, if0.rom_valid}, 32'd0);
        check("mr_data",   {24'd0, if0.rom_data},  32'd0);
        check("mr_loaded", {31'd0, loaded0},       32'd0);
        check("mr_count",  {15'd0, cnt0},          32'd0);
        @(negedge clk);
        rstv[0] = 1'b1;
        @(posedge clk);
        #1;
        check("mr_ready", {31'd0, if0.load_ready}, 32'd1);
        send(4'b0001, 8'h61, 1'b0);
        send(4'b0001, 8'h62, 1'b0);
        send(4'b0001, 8'h63, 1'b0);
        check("ml_count3", {15'd0, cnt0}, 32'd3);
        #2;
        rstv[0] = 1'b0;
        #1;
        check("ml_count",  {15'd0, cnt0}, 32'd0);
        check("ml_ready",  {31'd0, if0.load_ready}, 32'd0);
        check("ml_ovf",    {31'd0, ovf0}, 32'd0);
        @(negedge clk);
        rstv[0] = 1'b1;
        send(4'b0001, 8'h78, 1'b0);
        send(4'b0001, 8'h79, 1'b1);
        check("rl_count",  {15'd0, cnt0}, 32'd2);
        check("rl_ovf",    {31'd0, ovf0}, 32'd0);
        check("rl_loaded", {31'd0, loaded0}, 32'd1);
        @(negedge clk);
        addr = 17'd2;
        wait_valid(4'b0001, 8'h00, "rl_a2");
        @(negedge clk);
        addr = 17'd1;
        wait_valid(4'b0001, 8'h79, "rl_a1");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
